// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment patterns (active-low {g,f,e,d,c,b,a}), invalid BCD code and scan-decoder states
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  typedef enum logic {SYNC, COLLECT} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: inverse segment table; seg[6:0] active-low pattern in, bcd[3:0] and err (unknown pattern, incl. blank) out
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed 7-segment bus and publishes coherent decoded frames.
// Ports: clk, rst_n (async active-low); seg[6:0] active-low segments, an[NUM_DIGITS-1:0] active-low enables (both async);
// bcd_out (digit i at [4i+3:4i]), digit_err per digit, frame_valid pulse, frame_err with frame_valid, sync_err pulse.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    sync_err
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = NUM_DIGITS + 7;
  logic [SW-1:0] s1, s2, smp;
  logic [3:0] cnt, dec_bcd;
  logic [NUM_DIGITS-1:0] en, sh_err;
  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [IW-1:0] idx, expected, exp_d, prv;
  state_t state, state_d;
  logic captured, change, cap, one_hot, multi, dec_err, wr, pub, pub_d, serr_d;
  seg7_to_bcd u_dec (.seg(smp[6:0]), .bcd(dec_bcd), .err(dec_err));
  assign en      = ~smp[SW-1:7];
  assign change  = s2 != smp;
  assign cap     = cnt == 4'(STABLE_CYCLES - 1) && !captured;
  assign one_hot = |en && (en & (en - NUM_DIGITS'(1))) == '0;
  assign multi   = |en && !one_hot;
  // digit index that expected-1 refers to, wrapping after a completed frame
  assign prv     = expected == '0 ? IW'(NUM_DIGITS - 1) : expected - IW'(1);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (en[i]) idx = IW'(i);
  end
  always_comb begin
    state_d = state;
    exp_d   = expected;
    wr      = 1'b0;
    pub_d   = 1'b0;
    serr_d  = 1'b0;
    if (cap && multi) begin
      serr_d  = state == COLLECT;
      state_d = SYNC;
    end else if (cap && one_hot) begin
      if (state == SYNC) begin
        if (idx == '0) begin
          wr      = 1'b1;
          exp_d   = IW'(1);
          state_d = COLLECT;
        end
      end else if (idx == expected) begin
        wr    = 1'b1;
        pub_d = idx == IW'(NUM_DIGITS - 1);
        exp_d = pub_d ? '0 : expected + IW'(1);
      end else if (idx != prv) begin
        serr_d  = 1'b1;
        wr      = idx == '0;
        exp_d   = wr ? IW'(1) : expected;
        state_d = wr ? COLLECT : SYNC;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '1;
      s2          <= '1;
      smp         <= '1;
      cnt         <= '0;
      captured    <= 1'b0;
      state       <= SYNC;
      expected    <= '0;
      sh_bcd      <= '0;
      sh_err      <= '0;
      pub         <= 1'b0;
      bcd_out     <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      s1          <= {an, seg};
      s2          <= s1;
      smp         <= s2;
      cnt         <= change ? '0 : (cnt == 4'hF ? cnt : cnt + 4'd1);
      captured    <= !change && (captured || cap);
      state       <= state_d;
      expected    <= exp_d;
      if (wr) begin
        sh_bcd[idx*4 +: 4] <= dec_bcd;
        sh_err[idx]        <= dec_err;
      end
      pub         <= pub_d;
      frame_valid <= pub;
      frame_err   <= pub && |sh_err;
      if (pub) begin
        bcd_out   <= sh_bcd;
        digit_err <= sh_err;
      end
      sync_err    <= serr_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench; scans push expected frames, a negedge monitor pops and compares
module tb_seg7_scan_decoder;
  import seg7_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] seg = SEG_BLANK;
  logic [3:0] an = 4'hF;
  logic [15:0] bcd_out;
  logic [3:0] digit_err;
  logic frame_valid, frame_err, sync_err;
  int checks = 0, failures = 0, serr_cnt = 0, frame_cnt = 0;
  typedef struct packed {logic [15:0] b; logic [3:0] e; logic f;} exp_t;
  exp_t q[$];
  exp_t em;
  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .bcd_out(bcd_out),
    .digit_err(digit_err), .frame_valid(frame_valid), .frame_err(frame_err), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (sync_err) serr_cnt++;
    if (frame_valid) begin
      frame_cnt++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got bcd_out %h digit_err %b, no frame expected", bcd_out, digit_err);
      end else begin
        em = q.pop_front();
        chk("frame_bcd", 32'(bcd_out), 32'(em.b));
        chk("frame_digit_err", 32'(digit_err), 32'(em.e));
        chk("frame_err", 32'(frame_err), 32'(em.f));
      end
    end
  end
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic scan(input logic [6:0] d0, d1, d2, d3);
    show(4'b1110, d0, 8);
    show(4'b1101, d1, 8);
    show(4'b1011, d2, 8);
    show(4'b0111, d3, 8);
    show(4'b1111, SEG_BLANK, 12);
  endtask
  initial begin
    #23;
    chk("reset_bcd_out", 32'(bcd_out), 0);
    chk("reset_digit_err", 32'(digit_err), 0);
    chk("reset_frame_valid", 32'(frame_valid), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_sync_err", 32'(sync_err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    show(4'b1111, SEG_BLANK, 8);
    q.push_back('{16'h1234, 4'b0000, 1'b0});
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    chk("frames_pending_t1", 32'(q.size()), 0);
    q.push_back('{16'h1F34, 4'b0100, 1'b1});
    scan(SEG_4, SEG_3, SEG_BLANK, SEG_1);
    chk("frames_pending_t2", 32'(q.size()), 0);
    show(4'b1110, SEG_5, 8);
    show(4'b1101, SEG_6, 3);
    show(4'b1111, SEG_BLANK, 8);
    chk("short_digit_no_frame", 32'(frame_cnt), 2);
    q.push_back('{16'h8765, 4'b0000, 1'b0});
    show(4'b1101, SEG_6, 4);
    show(4'b1011, SEG_7, 8);
    show(4'b0111, SEG_8, 8);
    show(4'b1111, SEG_BLANK, 12);
    chk("frames_pending_t3", 32'(q.size()), 0);
    chk("sync_err_none_t3", 32'(serr_cnt), 0);
    show(4'b1110, SEG_9, 8);
    show(4'b1101, SEG_0, 8);
    show(4'b0111, SEG_1, 8);
    show(4'b1111, SEG_BLANK, 12);
    chk("sync_err_skip", 32'(serr_cnt), 1);
    chk("skip_no_frame", 32'(frame_cnt), 3);
    q.push_back('{16'h7890, 4'b0000, 1'b0});
    scan(SEG_0, SEG_9, SEG_8, SEG_7);
    chk("frames_pending_t4", 32'(q.size()), 0);
    show(4'b1110, SEG_3, 8);
    show(4'b1101, SEG_3, 8);
    show(4'b1100, SEG_8, 8);
    show(4'b1111, SEG_BLANK, 8);
    chk("sync_err_multi", 32'(serr_cnt), 2);
    show(4'b1011, SEG_3, 8);
    show(4'b0111, SEG_3, 8);
    show(4'b1111, SEG_BLANK, 12);
    chk("hold_bcd_out", 32'(bcd_out), 32'h7890);
    chk("hold_digit_err", 32'(digit_err), 0);
    chk("sync_no_frame", 32'(frame_cnt), 4);
    show(4'b1110, SEG_6, 8);
    show(4'b1101, SEG_6, 8);
    #4 rst_n = 1'b0;
    #1;
    chk("async_rst_bcd_out", 32'(bcd_out), 0);
    chk("async_rst_digit_err", 32'(digit_err), 0);
    chk("async_rst_flags", 32'({frame_valid, frame_err, sync_err}), 0);
    an  = 4'hF;
    seg = SEG_BLANK;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    show(4'b1111, SEG_BLANK, 8);
    show(4'b1101, SEG_2, 8);
    show(4'b1011, SEG_3, 8);
    show(4'b0111, SEG_4, 8);
    show(4'b1111, SEG_BLANK, 12);
    chk("post_rst_partial_no_frame", 32'(frame_cnt), 4);
    chk("post_rst_bcd_zero", 32'(bcd_out), 0);
    q.push_back('{16'h4321, 4'b0000, 1'b0});
    scan(SEG_1, SEG_2, SEG_3, SEG_4);
    chk("frames_pending_t6", 32'(q.size()), 0);
    chk("total_frames", 32'(frame_cnt), 5);
    chk("total_sync_err", 32'(serr_cnt), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display interface: snoops an externally driven, time-multiplexed display bus (active-low segment lines plus active-low digit enables).
- Recovers the BCD value of every digit, flags undecodable patterns, and publishes one complete, coherent frame per scan cycle.
- Used for display-loopback checking and for reading values off third-party display drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured (2..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}, asynchronous to clk
an  input  NUM_DIGITS  digit enables, active-low, one-hot when a digit is lit, asynchronous to clk
bcd_out  output  4*NUM_DIGITS  decoded frame, digit i at bcd_out[4i+3:4i]
digit_err  output  NUM_DIGITS  per-digit undecodable-pattern flags for the published frame
frame_valid  output  1  one-cycle pulse when bcd_out/digit_err update
frame_err  output  1  high with frame_valid when any digit_err bit set; otherwise 0
sync_err  output  1  one-cycle pulse on protocol violation during collection

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All outputs 0 during reset and in the cycle after deassertion. FSM enters SYNC.
- Input synchronization: seg and an each pass through a 2-flop synchronizer.
- Stability filter:
  - Counter increments while the synchronized {an,seg} equals the previous sample; clears to 0 on any change.
  - A capture event fires once, on the sample where the count reaches STABLE_CYCLES-1.
  - A "captured" flag blocks re-capture until {an,seg} changes.
  - Counter saturates; no wrap.
- Latency: pin change to capture = 2 + STABLE_CYCLES clk cycles.
- Capture qualification:
  - an all ones (blanking): no capture, no error.
  - an one-hot (exactly one 0): capture with index = position of the 0.
  - More than one 0: no capture. sync_err pulses if in COLLECT, then FSM returns to SYNC.
- Decode (combinational):
  - Pattern table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other pattern, including blank 1111111, decodes to 4'hF with error=1.
- FSM, two states:
  - SYNC: ignores captures except index 0. Index 0 stores into shadow slot 0, sets expected=1, moves to COLLECT.
  - COLLECT, capture index == expected: store digit and error into shadow; expected++.
    - If the stored index was NUM_DIGITS-1: next cycle, copy shadow to bcd_out/digit_err, pulse frame_valid, set frame_err = OR of shadow errors. Then expected=0 and FSM stays in COLLECT.
  - COLLECT, capture index == expected-1 (same digit re-lit): ignored, no error.
  - COLLECT, any other index: pulse sync_err and discard the shadow.
    - If that index is 0, restart with slot 0 stored and expected=1.
    - Otherwise go to SYNC.
- bcd_out and digit_err hold their values between frames; a partial frame never reaches them.
- Reset mid-frame: shadow and outputs clear immediately; first frame_valid after reset requires a full 0..NUM_DIGITS-1 scan.
- Simultaneous events: capture and frame publication never coincide in the same cycle for the same digit (publication is registered one cycle later). A capture arriving in the publication cycle is processed normally against expected=0.

Decomposition:
- Package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants (shared with the existing BCD-to-segment encoder).
  - BCD_INVALID = 4'hF.
  - State enum {SYNC, COLLECT}.
- One sub-module seg7_to_bcd: combinational inverse table, seg[6:0] -> bcd[3:0], err.

Test Plan:
- rst_n low mid-collection (after digits 0,1 captured) -> all outputs 0 asynchronously. A following scan starting at digit 1 produces nothing until digit 0 appears.
- Scan an=1110,1101,1011,0111 with seg=0011001,0110000,0100100,1111001, each held 8 cycles, STABLE_CYCLES=4 -> one frame_valid, bcd_out=16'h1234, digit_err=0, frame_err=0.
- Same scan with digit 2 seg=1111111 -> bcd_out=16'h1F34, digit_err=4'b0100, frame_err=1.
- Digit 1 held only 3 synchronized cycles before the next change -> no capture for digit 1, no frame_valid. Digit 1 held 4 cycles -> captured.
- Scan order 0,1,3 -> sync_err pulse on digit 3, no frame_valid. Then a clean 0..3 scan -> frame_valid with correct data.
- an=1100 held 8 cycles during COLLECT -> sync_err pulse, FSM in SYNC, bcd_out unchanged from the previous frame.
